hack_cpu_ctrl: RTL and testbench

//  Multi-cycle Hack control/sequencer: the driving end of the ALU control interface.

---
 rtl/hack_cpu_ctrl_pkg.sv | 27 ++
 rtl/hack_cpu_ctrl_decode.sv | 40 ++++
 rtl/hack_cpu_ctrl.sv | 152 +++++++++++++++
 tb/tb_hack_cpu_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_cpu_ctrl_pkg.sv
// Shared definitions for the Hack control sequencer: FSM state encoding,
// instruction field positions and a small field-extraction helper.
package hack_cpu_ctrl_pkg;

  // Sequencer states, one per phase of an instruction's life
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_MEMRD  = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_COMMIT = 3'd5
  } state_t;

  // Instruction word field positions
  localparam int BIT_CI = 15;
  localparam int BIT_A  = 12;
  localparam int C_MSB  = 11;
  localparam int D_MSB  = 5;
  localparam int J_MSB  = 2;

  // ALU control bits zx,nx,zy,ny,f,no as one vector, MSB first
  function automatic logic [5:0] aluCtrlOf(input logic [15:0] ir);
    return ir[C_MSB -: 6];
  endfunction

endpackage

// File: rtl/hack_cpu_ctrl_decode.sv
// Combinational instruction decoder: splits the held instruction word into
// class, operand select, ALU controls, destinations and the jump decision.
// The jump decision uses the flags captured from the ALU during execute.
module hack_cpu_ctrl_decode
  import hack_cpu_ctrl_pkg::*;
(
  input  logic [15:0] i_ir,
  input  logic        i_zr,
  input  logic        i_ng,
  output logic        o_isC,
  output logic        o_useM,
  output logic [5:0]  o_ctrl,
  output logic        o_dA,
  output logic        o_dD,
  output logic        o_dM,
  output logic        o_jump
);

  logic [2:0] w_dest;
  logic [2:0] w_jmp;
  logic       w_unusedBits;

  // Field split and jump condition; lt/eq/gt are mutually exclusive, so
  // j=111 always jumps and j=000 never does
  always_comb begin
    w_dest       = i_ir[D_MSB -: 3];
    w_jmp        = i_ir[J_MSB -: 3];
    o_isC        = i_ir[BIT_CI];
    o_useM       = i_ir[BIT_CI] & i_ir[BIT_A];
    o_ctrl       = aluCtrlOf(i_ir);
    o_dA         = o_isC & w_dest[2];
    o_dD         = o_isC & w_dest[1];
    o_dM         = o_isC & w_dest[0];
    o_jump       = o_isC & ((w_jmp[2] & i_ng) |
                            (w_jmp[1] & i_zr) |
                            (w_jmp[0] & ~i_ng & ~i_zr));
    w_unusedBits = &{1'b0, i_ir[14:13]};
  end

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack control sequencer. Fetches instructions over the ROM
// req/ack port, drives an external combinational ALU, holds A/D/PC and
// reaches data memory over the RAM req/ack port.
module hack_cpu_ctrl
  import hack_cpu_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 15,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_ack,
  input  logic [15:0]       rom_data,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_wdata,
  input  logic              ram_ack,
  input  logic [15:0]       ram_rdata,
  output logic [15:0]       alu_x,
  output logic [15:0]       alu_y,
  output logic              alu_zx,
  output logic              alu_nx,
  output logic              alu_zy,
  output logic              alu_ny,
  output logic              alu_f,
  output logic              alu_no,
  input  logic [15:0]       alu_out,
  input  logic              alu_zr,
  input  logic              alu_ng,
  output logic [ADDR_W-1:0] pc,
  output logic              instr_done
);

  state_t            r_state;
  state_t            w_next;
  logic [15:0]       r_a;
  logic [15:0]       r_d;
  logic [15:0]       r_ir;
  logic [15:0]       r_m;
  logic [15:0]       r_r;
  logic              r_zr;
  logic              r_ng;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pcInc;
  logic              w_isC;
  logic              w_useM;
  logic [5:0]        w_ctrl;
  logic              w_dA;
  logic              w_dD;
  logic              w_dM;
  logic              w_jump;

  hack_cpu_ctrl_decode u_decode (
    .i_ir   (r_ir),
    .i_zr   (r_zr),
    .i_ng   (r_ng),
    .o_isC  (w_isC),
    .o_useM (w_useM),
    .o_ctrl (w_ctrl),
    .o_dA   (w_dA),
    .o_dD   (w_dD),
    .o_dM   (w_dM),
    .o_jump (w_jump)
  );

  assign w_pcInc = r_pc + ADDR_W'(1);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_FETCH;
    else          r_state <= w_next;
  end

  // Next-state logic; acks only matter in the states that raise the request
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_FETCH:  if (rom_ack) w_next = ST_DECODE;
      ST_DECODE: begin
        if (!w_isC)      w_next = ST_FETCH;
        else if (w_useM) w_next = ST_MEMRD;
        else             w_next = ST_EXEC;
      end
      ST_MEMRD:  if (ram_ack) w_next = ST_EXEC;
      ST_EXEC:   w_next = w_dM ? ST_WRITE : ST_COMMIT;
      ST_WRITE:  if (ram_ack) w_next = ST_COMMIT;
      ST_COMMIT: w_next = ST_FETCH;
      default:   w_next = ST_FETCH;
    endcase
  end

  // Handshake and retire outputs; requests are gated by reset so they drop
  // the moment reset is asserted even though the reset state is FETCH
  always_comb begin
    rom_req    = reset_n & (r_state == ST_FETCH);
    ram_req    = reset_n & ((r_state == ST_MEMRD) | (r_state == ST_WRITE));
    ram_we     = reset_n & (r_state == ST_WRITE);
    instr_done = ((r_state == ST_DECODE) & ~w_isC) | (r_state == ST_COMMIT);
  end

  // Datapath towards memories and ALU; A is only updated at retire, so the
  // data address and jump target always see the pre-instruction A
  always_comb begin
    rom_addr  = r_pc;
    pc        = r_pc;
    ram_addr  = r_a[ADDR_W-1:0];
    ram_wdata = r_r;
    alu_x     = r_d;
    alu_y     = r_ir[BIT_A] ? r_m : r_a;
    {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = w_ctrl;
  end

  // Architectural and pipeline registers, each written in its own phase
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a  <= '0;
      r_d  <= '0;
      r_ir <= '0;
      r_m  <= '0;
      r_r  <= '0;
      r_zr <= 1'b0;
      r_ng <= 1'b0;
      r_pc <= ADDR_W'(RESET_PC);
    end else begin
      case (r_state)
        ST_FETCH:  if (rom_ack) r_ir <= rom_data;
        ST_DECODE: begin
          if (!w_isC) begin
            r_a  <= r_ir;
            r_pc <= w_pcInc;
          end
        end
        ST_MEMRD:  if (ram_ack) r_m <= ram_rdata;
        ST_EXEC: begin
          r_r  <= alu_out;
          r_zr <= alu_zr;
          r_ng <= alu_ng;
        end
        ST_COMMIT: begin
          if (w_dA) r_a <= r_r;
          if (w_dD) r_d <= r_r;
          r_pc <= w_jump ? r_a[ADDR_W-1:0] : w_pcInc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Directed bench for hack_cpu_ctrl: ROM/RAM responders with programmable
// ack delay, a behavioural Hack ALU, and a linear program of checks.
module tb_hack_cpu_ctrl;

  logic        clk;
  logic        reset_n;
  logic        rom_req;
  logic [14:0] rom_addr;
  logic        rom_ack;
  logic [15:0] rom_data;
  logic        ram_req;
  logic        ram_we;
  logic [14:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_ack;
  logic [15:0] ram_rdata;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
  logic [15:0] alu_out;
  logic        alu_zr;
  logic        alu_ng;
  logic [14:0] pc;
  logic        instr_done;

  logic [15:0] rom [0:63];
  logic [15:0] ram [0:63];
  int romDelay, ramDelay, romWait, ramWait;
  int ramReads, ramWrites, lastRaddr, lastWaddr;
  logic [15:0] lastWdata;
  int total, bad;
  int cyc, cycD;
  logic [15:0] mx, my, mo;

  hack_cpu_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_data(rom_data),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_ack(ram_ack), .ram_rdata(ram_rdata),
    .alu_x(alu_x), .alu_y(alu_y),
    .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny),
    .alu_f(alu_f), .alu_no(alu_no),
    .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
    .pc(pc), .instr_done(instr_done)
  );

  // Free-running clock, posedge at 5, 15, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural Hack ALU sitting on the control interface
  always_comb begin
    mx      = alu_zx ? 16'h0000 : alu_x;
    mx      = alu_nx ? ~mx : mx;
    my      = alu_zy ? 16'h0000 : alu_y;
    my      = alu_ny ? ~my : my;
    mo      = alu_f ? (mx + my) : (mx & my);
    mo      = alu_no ? ~mo : mo;
    alu_out = mo;
    alu_zr  = (mo == 16'h0000);
    alu_ng  = mo[15];
  end

  // ROM responder: acks after romDelay waiting cycles
  initial begin
    rom_ack  = 1'b0;
    rom_data = 16'h0000;
    romWait  = 0;
    forever begin
      @(negedge clk);
      if (rom_req && !rom_ack) begin
        if (romWait >= romDelay) begin
          rom_ack  = 1'b1;
          rom_data = rom[rom_addr[5:0]];
          romWait  = 0;
        end else begin
          romWait++;
        end
      end else begin
        rom_ack = 1'b0;
        romWait = 0;
      end
    end
  end

  // RAM responder: acks after ramDelay waiting cycles and logs traffic
  initial begin
    ram_ack   = 1'b0;
    ram_rdata = 16'h0000;
    ramWait   = 0;
    forever begin
      @(negedge clk);
      if (ram_req && !ram_ack) begin
        if (ramWait >= ramDelay) begin
          ram_ack = 1'b1;
          ramWait = 0;
          if (ram_we) begin
            ram[ram_addr[5:0]] = ram_wdata;
            ramWrites++;
            lastWaddr = int'(ram_addr);
            lastWdata = ram_wdata;
          end else begin
            ram_rdata = ram[ram_addr[5:0]];
            ramReads++;
            lastRaddr = int'(ram_addr);
          end
        end else begin
          ramWait++;
        end
      end else begin
        ram_ack = 1'b0;
        ramWait = 0;
      end
    end
  end

  // One immediate-assertion comparison
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Run one instruction from a FETCH negedge until it retires; returns the
  // cycle count and leaves the bench at the following negedge
  task automatic applyStimulus(output int cycles);
    bit done;
    done   = 1'b0;
    cycles = 0;
    while (!done && cycles < 40) begin
      cycles++;
      if (instr_done === 1'b1) done = 1'b1;
      else @(negedge clk);
    end
    if (!done) checkOutput("retire_timeout", 32'(done), 32'd1);
    @(negedge clk);
  endtask

  // All outputs at their reset values
  task automatic checkReset(input string tag);
    checkOutput({tag, "_rom_req"}, 32'(rom_req), 32'd0);
    checkOutput({tag, "_ram_req"}, 32'(ram_req), 32'd0);
    checkOutput({tag, "_ram_we"}, 32'(ram_we), 32'd0);
    checkOutput({tag, "_done"}, 32'(instr_done), 32'd0);
    checkOutput({tag, "_pc"}, 32'(pc), 32'd0);
    checkOutput({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    checkOutput({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    checkOutput({tag, "_wdata"}, 32'(ram_wdata), 32'd0);
    checkOutput({tag, "_alu_x"}, 32'(alu_x), 32'd0);
    checkOutput({tag, "_alu_y"}, 32'(alu_y), 32'd0);
    checkOutput({tag, "_ctrl"}, 32'({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}), 32'd0);
  endtask

  initial begin
    total = 0; bad = 0;
    romDelay = 0; ramDelay = 0;
    ramReads = 0; ramWrites = 0; lastRaddr = -1; lastWaddr = -1; lastWdata = '0;
    reset_n = 1'b0;
    for (int i = 0; i < 64; i++) begin
      rom[i] = 16'hEA80;
      ram[i] = 16'h0000;
    end
    rom[0]  = 16'h0005;
    rom[1]  = 16'h0007;
    rom[2]  = 16'hEC10;
    rom[3]  = 16'hE090;
    rom[4]  = 16'h0064;
    rom[5]  = 16'hEE88;
    rom[6]  = 16'h0003;
    rom[7]  = 16'hFC10;
    rom[8]  = 16'hEA90;
    rom[9]  = 16'h0014;
    rom[10] = 16'hE302;
    rom[20] = 16'hEFD0;
    rom[21] = 16'h001E;
    rom[22] = 16'hE302;
    rom[23] = 16'h7FFF;
    rom[24] = 16'hEA87;
    rom[63] = 16'hE302;
    ram[3]  = 16'h0009;

    repeat (2) @(negedge clk);
    checkReset("reset");

    @(posedge clk); #2 reset_n = 1'b1;
    @(negedge clk);

    applyStimulus(cyc);
    checkOutput("a_latency", 32'(cyc), 32'd2);
    checkOutput("a_pc", 32'(pc), 32'd1);
    checkOutput("a_value", 32'(ram_addr), 32'd5);
    checkOutput("a_no_ram", 32'(ramReads + ramWrites), 32'd0);

    applyStimulus(cyc);
    checkOutput("a7_value", 32'(ram_addr), 32'd7);
    applyStimulus(cycD);
    checkOutput("d_eq_a", 32'(alu_x), 32'd7);
    checkOutput("d_eq_a_pc", 32'(pc), 32'd3);
    applyStimulus(cyc);
    checkOutput("d_plus_a", 32'(alu_x), 32'd14);
    checkOutput("d_plus_a_ctrl", 32'({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}), 32'b000010);
    checkOutput("c_latency_same", 32'(cyc), 32'(cycD));

    applyStimulus(cyc);
    applyStimulus(cyc);
    checkOutput("mw_latency", 32'(cyc), 32'(cycD + 1));
    checkOutput("mw_writes", 32'(ramWrites), 32'd1);
    checkOutput("mw_reads", 32'(ramReads), 32'd0);
    checkOutput("mw_addr", 32'(lastWaddr), 32'd100);
    checkOutput("mw_wdata", 32'(lastWdata), 32'hFFFF);
    checkOutput("mw_d_kept", 32'(alu_x), 32'd14);
    checkOutput("mw_pc", 32'(pc), 32'd6);

    applyStimulus(cyc);
    applyStimulus(cyc);
    checkOutput("mr_latency", 32'(cyc), 32'(cycD + 1));
    checkOutput("mr_reads", 32'(ramReads), 32'd1);
    checkOutput("mr_addr", 32'(lastRaddr), 32'd3);
    checkOutput("mr_alu_y", 32'(alu_y), 32'd9);
    checkOutput("mr_d", 32'(alu_x), 32'd9);
    checkOutput("mr_writes", 32'(ramWrites), 32'd1);

    applyStimulus(cyc);
    checkOutput("d_zero", 32'(alu_x), 32'd0);
    applyStimulus(cyc);
    applyStimulus(cyc);
    checkOutput("jeq_taken_pc", 32'(pc), 32'd20);
    applyStimulus(cyc);
    checkOutput("d_one", 32'(alu_x), 32'd1);
    applyStimulus(cyc);
    applyStimulus(cyc);
    checkOutput("jeq_not_taken_pc", 32'(pc), 32'd23);
    applyStimulus(cyc);
    checkOutput("a_max", 32'(ram_addr), 32'h7FFF);
    applyStimulus(cyc);
    checkOutput("jmp_pc", 32'(pc), 32'h7FFF);
    checkOutput("jmp_rom_addr", 32'(rom_addr), 32'h7FFF);
    applyStimulus(cyc);
    checkOutput("pc_wrap", 32'(pc), 32'd0);

    #1 reset_n = 1'b0;
    rom[0]   = 16'h0003;
    rom[1]   = 16'hFC10;
    romDelay = 4;
    ramDelay = 4;
    repeat (2) @(negedge clk);
    @(posedge clk); #2 reset_n = 1'b1;
    @(negedge clk);

    applyStimulus(cyc);
    checkOutput("slow_a_latency", 32'(cyc), 32'd6);
    checkOutput("slow_a_pc", 32'(pc), 32'd1);
    checkOutput("slow_a_value", 32'(ram_addr), 32'd3);

    repeat (6) @(negedge clk);
    checkOutput("memrd_req", 32'(ram_req), 32'd1);
    checkOutput("memrd_we", 32'(ram_we), 32'd0);
    checkOutput("memrd_rom_idle", 32'(rom_req), 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("memrd_req_held", 32'(ram_req), 32'd1);
    #1 reset_n = 1'b0;
    #1 checkReset("midreset");
    checkOutput("midreset_reads", 32'(ramReads), 32'd1);

    repeat (2) @(negedge clk);
    checkOutput("midreset_reads_later", 32'(ramReads), 32'd1);
    @(posedge clk); #2 reset_n = 1'b1;
    @(negedge clk);
    applyStimulus(cyc);
    checkOutput("restart_latency", 32'(cyc), 32'd6);
    checkOutput("restart_pc", 32'(pc), 32'd1);
    checkOutput("restart_d", 32'(alu_x), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
